// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch queue.
package fetch_pkg;

   typedef struct packed {
      logic [31:0] inst;
      logic [31:0] pc4;
   } fq_entry_t;

   localparam logic [31:0] NOP_INST = 32'h0000_0000;
   localparam logic [31:0] PC_STEP  = 32'd4;

   // Sequential fetch address; wraps modulo 2^32.
   function automatic logic [31:0] pc_next(input logic [31:0] pc);
      return pc + PC_STEP;
   endfunction

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory request/response port and the IF/ID-facing queue head port.
// Handshake: the head transfers on a clock edge where out_valid && out_ready; out_valid
// never waits on out_ready. imem_req is a one-cycle pulse; imem_rvalid answers it later.
interface fetch_queue_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc4;
   logic        out_ready;

   modport master (
      output imem_req, imem_addr, out_valid, out_inst, out_pc4,
      input  imem_rvalid, imem_rdata, out_ready
   );

   modport slave (
      input  imem_req, imem_addr, out_valid, out_inst, out_pc4,
      output imem_rvalid, imem_rdata, out_ready
   );
endinterface

// File: rtl/fetch_fifo_mem.sv
// Entry storage and read/write pointers for the fetch queue; occupancy is tracked by the owner.
module fetch_fifo_mem
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      clear,
   input  logic      wr_en,
   input  fq_entry_t wr_data,
   input  logic      rd_en,
   output fq_entry_t rd_data
);

   localparam int PW = $clog2(DEPTH);

   fq_entry_t         mem_q [DEPTH];
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

   // DEPTH is a power of two, so the pointers wrap by plain overflow.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_en) wr_ptr_d = wr_ptr_q + PW'(1);
         if (rd_en) rd_ptr_d = rd_ptr_q + PW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !clear) mem_q[wr_ptr_q] <= wr_data;
   end

   assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch queue feeding IF/ID from a variable-latency instruction memory.
// Optional same-cycle response bypass when the queue is empty: define FETCHQ_BYPASS_EN.
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   redirect,
   input  logic [31:0]            redirect_pc,
   fetch_queue_if.master          bus,
   output logic [$clog2(DEPTH):0] count
);

   localparam int             CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [31:0]   fetch_pc_q, fetch_pc_d;
   logic [31:0]   req_pc_q, req_pc_d;
   logic          outstanding_q, outstanding_d;
   logic          discard_q, discard_d;
   logic [CW-1:0] count_q, count_d;

   logic          resp, issue, enq, deq, bypass, head_valid;
   fq_entry_t     resp_entry, head_entry;

   fetch_fifo_mem #(.DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .clear   (redirect),
      .wr_en   (enq),
      .wr_data (resp_entry),
      .rd_en   (deq),
      .rd_data (head_entry)
   );

   always_comb begin
      resp            = bus.imem_rvalid && outstanding_q;
      head_valid      = (count_q != '0);
      issue           = !redirect && !outstanding_q && (count_q < FULL);
      resp_entry.inst = bus.imem_rdata;
      resp_entry.pc4  = pc_next(req_pc_q);
      bypass          = 1'b0;
`ifdef FETCHQ_BYPASS_EN
      bypass          = !head_valid && !discard_q && !redirect && resp;
`endif
      // A bypassed word taken by IF/ID in the same cycle never occupies a slot.
      enq             = resp && !discard_q && !redirect && !(bypass && bus.out_ready);
      deq             = head_valid && bus.out_ready && !redirect;

      bus.imem_req    = issue && !rst;
      bus.imem_addr   = fetch_pc_q;
      bus.out_valid   = head_valid || bypass;
      bus.out_inst    = NOP_INST;
      bus.out_pc4     = '0;
      if (head_valid) begin
         bus.out_inst = head_entry.inst;
         bus.out_pc4  = head_entry.pc4;
      end else if (bypass) begin
         bus.out_inst = resp_entry.inst;
         bus.out_pc4  = resp_entry.pc4;
      end
   end

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      req_pc_d      = req_pc_q;
      outstanding_d = outstanding_q;
      discard_d     = discard_q;
      count_d       = count_q + CW'(enq) - CW'(deq);
      if (resp) outstanding_d = 1'b0;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         count_d    = '0;
         // Only a request still in flight needs its eventual word thrown away.
         discard_d  = outstanding_q && !bus.imem_rvalid;
      end else begin
         if (resp) discard_d = 1'b0;
         if (issue) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
            fetch_pc_d    = pc_next(fetch_pc_q);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         req_pc_q      <= RESET_PC;
         outstanding_q <= 1'b0;
         discard_q     <= 1'b0;
         count_q       <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         req_pc_q      <= req_pc_d;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         count_q       <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a latency-programmable instruction memory model.
// Expectations for the bypass step follow FETCHQ_BYPASS_EN when it is defined.
module tb_fetch_queue;

   logic        clk = 1'b0;
   logic        rst;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic [2:0]  count;

   int          checks = 0;
   int          errors = 0;

   int          lat = 1;
   logic        ovr = 1'b0;
   logic [31:0] ovr_data = 32'h0;
   logic        req_s, rst_s, pend = 1'b0;
   logic [31:0] addr_s, pend_addr;
   int          pend_cnt;
   int          n_req;

   fetch_queue_if bus ();

   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
      .clk         (clk),
      .rst         (rst),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .bus         (bus),
      .count       (count)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a + 32'h1000_0000;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst      = 1'b1;
      redirect = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // Memory model: answers a request lat cycles after the request cycle.
   always @(posedge clk) begin
      req_s  = bus.imem_req;
      addr_s = bus.imem_addr;
      rst_s  = rst;
      #1;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      if (rst_s) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            pend_cnt--;
            if (pend_cnt == 0) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = ovr ? ovr_data : word_of(pend_addr);
               pend            = 1'b0;
            end
         end
         if (req_s) begin
            if (lat == 1) begin
               bus.imem_rvalid = 1'b1;
               bus.imem_rdata  = ovr ? ovr_data : word_of(addr_s);
            end else begin
               pend      = 1'b1;
               pend_cnt  = lat - 1;
               pend_addr = addr_s;
            end
         end
      end
   end

   initial begin
      rst           = 1'b1;
      redirect      = 1'b0;
      redirect_pc   = 32'h0;
      bus.out_ready = 1'b1;
      lat           = 1;
      repeat (2) @(negedge clk);
      check("rst_count", 32'(count), 32'd0);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_out_inst", bus.out_inst, 32'h0);
      check("rst_out_pc4", bus.out_pc4, 32'h0);
      check("rst_imem_req", 32'(bus.imem_req), 32'd0);
      check("rst_imem_addr", bus.imem_addr, 32'h0);

      // Streaming at 1-cycle latency with IF/ID always ready.
      rst = 1'b0;
      #1;
      check("s1_req0", 32'(bus.imem_req), 32'd1);
      check("s1_addr0", bus.imem_addr, 32'h0);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
`ifdef FETCHQ_BYPASS_EN
         check("s1_byp_valid", 32'(bus.out_valid), 32'd1);
         check("s1_byp_pc4", bus.out_pc4, 32'(4 * k));
         check("s1_byp_inst", bus.out_inst, word_of(32'(4 * k - 4)));
         @(negedge clk);
         check("s1_byp_idle", 32'(bus.out_valid), 32'd0);
`else
         check("s1_idle_valid", 32'(bus.out_valid), 32'd0);
         check("s1_idle_req", 32'(bus.imem_req), 32'd0);
         @(negedge clk);
         check("s1_valid", 32'(bus.out_valid), 32'd1);
         check("s1_pc4", bus.out_pc4, 32'(4 * k));
         check("s1_inst", bus.out_inst, word_of(32'(4 * k - 4)));
`endif
         check("s1_req", 32'(bus.imem_req), 32'd1);
         check("s1_addr", bus.imem_addr, 32'(4 * k));
      end

      // Fill to full with IF/ID stalled, then pop one entry.
      bus.out_ready = 1'b0;
      do_reset();
      rst   = 1'b0;
      n_req = 0;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (bus.imem_req) n_req++;
         @(negedge clk);
      end
      check("full_req_total", 32'(n_req), 32'd4);
      check("full_count", 32'(count), 32'd4);
      check("full_no_req", 32'(bus.imem_req), 32'd0);
      check("full_addr", bus.imem_addr, 32'h10);
      check("full_head_pc4", bus.out_pc4, 32'h4);
      bus.out_ready = 1'b1;
      @(negedge clk);
      bus.out_ready = 1'b0;
      #1;
      check("pop_count", 32'(count), 32'd3);
      check("pop_req", 32'(bus.imem_req), 32'd1);
      check("pop_addr", bus.imem_addr, 32'h10);
      check("pop_head_pc4", bus.out_pc4, 32'h8);
      @(negedge clk);
      check("pop_wait_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      check("refull_count", 32'(count), 32'd4);
      check("refull_req", 32'(bus.imem_req), 32'd0);
      check("refull_addr", bus.imem_addr, 32'h14);

      // 3-cycle memory; redirect one cycle after the 0x8 request.
      lat = 3;
      do_reset();
      rst = 1'b0;
      #1;
      check("l3_addr0", bus.imem_addr, 32'h0);
      repeat (8) @(negedge clk);
      check("l3_req8", 32'(bus.imem_req), 32'd1);
      check("l3_addr8", bus.imem_addr, 32'h8);
      check("l3_count2", 32'(count), 32'd2);
      @(negedge clk);
      redirect    = 1'b1;
      redirect_pc = 32'h40;
      #1;
      check("rd1_no_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      check("rd1_count", 32'(count), 32'd0);
      check("rd1_wait_req", 32'(bus.imem_req), 32'd0);
      check("rd1_addr", bus.imem_addr, 32'h40);
      @(negedge clk);
      check("rd1_stale_valid", 32'(bus.out_valid), 32'd0);
      @(negedge clk);
      check("rd1_stale_count", 32'(count), 32'd0);
      check("rd1_req40", 32'(bus.imem_req), 32'd1);
      check("rd1_addr40", bus.imem_addr, 32'h40);
      repeat (4) @(negedge clk);
      check("rd1_head_valid", 32'(bus.out_valid), 32'd1);
      check("rd1_head_pc4", bus.out_pc4, 32'h44);
      check("rd1_head_inst", bus.out_inst, 32'h1000_0040);
      check("rd1_head_count", 32'(count), 32'd1);
      check("rd1_addr44", bus.imem_addr, 32'h44);

      // Redirect in the same cycle as the response, IF/ID ready.
      repeat (3) @(negedge clk);
      redirect      = 1'b1;
      redirect_pc   = 32'h80;
      bus.out_ready = 1'b1;
      #1;
      check("rd2_valid", 32'(bus.out_valid), 32'd1);
      check("rd2_count", 32'(count), 32'd1);
      check("rd2_no_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      redirect      = 1'b0;
      bus.out_ready = 1'b0;
      #1;
      check("rd2_flushed", 32'(count), 32'd0);
      check("rd2_out_valid", 32'(bus.out_valid), 32'd0);
      check("rd2_req", 32'(bus.imem_req), 32'd1);
      check("rd2_addr", bus.imem_addr, 32'h80);
      repeat (4) @(negedge clk);
      check("rd2_kept_count", 32'(count), 32'd1);
      check("rd2_kept_pc4", bus.out_pc4, 32'h84);
      check("rd2_kept_inst", bus.out_inst, 32'h1000_0080);

      // Address wrap from the top of the address space.
      lat = 1;
      do_reset();
      rst         = 1'b0;
      redirect    = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      #1;
      check("wrap_no_req", 32'(bus.imem_req), 32'd0);
      @(negedge clk);
      redirect = 1'b0;
      #1;
      check("wrap_req", 32'(bus.imem_req), 32'd1);
      check("wrap_addr_top", bus.imem_addr, 32'hFFFF_FFFC);
      repeat (2) @(negedge clk);
      check("wrap_count", 32'(count), 32'd1);
      check("wrap_pc4", bus.out_pc4, 32'h0);
      check("wrap_inst", bus.out_inst, 32'h0FFF_FFFC);
      check("wrap_addr0", bus.imem_addr, 32'h0);

      // Response into an empty queue with IF/ID ready.
      bus.out_ready = 1'b1;
      ovr           = 1'b1;
      ovr_data      = 32'h2002_0005;
      do_reset();
      rst = 1'b0;
      #1;
      check("byp_req", 32'(bus.imem_req), 32'd1);
      @(negedge clk);
`ifdef FETCHQ_BYPASS_EN
      check("byp_valid", 32'(bus.out_valid), 32'd1);
      check("byp_inst", bus.out_inst, 32'h2002_0005);
      check("byp_pc4", bus.out_pc4, 32'h4);
      check("byp_count", 32'(count), 32'd0);
      @(negedge clk);
      check("byp_after_count", 32'(count), 32'd0);
      check("byp_after_valid", 32'(bus.out_valid), 32'd0);
`else
      check("nobyp_valid", 32'(bus.out_valid), 32'd0);
      check("nobyp_count", 32'(count), 32'd0);
      @(negedge clk);
      check("nobyp_next_valid", 32'(bus.out_valid), 32'd1);
      check("nobyp_next_inst", bus.out_inst, 32'h2002_0005);
      check("nobyp_next_count", 32'(count), 32'd1);
`endif
      check("byp_next_addr", bus.imem_addr, 32'h4);
      ovr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "bench timeout");
   end

endmodule
